iecdrv_rom_sched: RTL and testbench

IECDRV_ROM_SCHED -- requirements
Module: iecdrv_rom_sched

---
 rtl/iecdrv_rom_sched.sv | 150 +++++++++++++++
 tb/tb_iecdrv_rom_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iecdrv_rom_sched.sv
// Shared-ROM fetch scheduler: time-slices one ROM read port across NDR drives.
// Each round issues one address per enabled drive and routes the data back by tag.
module iecdrv_rom_sched #(
   parameter int NDR     = 2,
   parameter int AW      = 15,
   parameter int DW      = 8,
   parameter int ROM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ph2_f,
   input  logic [NDR-1:0]    drv_en,
   input  logic [NDR*AW-1:0] drv_addr,
   output logic [AW-1:0]     mem_a,
   input  logic [DW-1:0]     rom_q,
   output logic [NDR*DW-1:0] drv_data,
   output logic [NDR-1:0]    drv_valid,
   output logic              busy,
   input  logic              ovr_clr,
   output logic              overrun
);

   localparam int PW = (NDR > 1) ? $clog2(NDR) : 1;
   localparam logic [ROM_LAT-1:0] TOP = ROM_LAT'(1) << (ROM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   state_t              state_q, state_d;
   logic [NDR-1:0]      mask_q, mask_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [AW-1:0]       mem_a_q, mem_a_d;
   logic [ROM_LAT-1:0]  tv_q, tv_d;
   logic [PW-1:0]       ti_q [ROM_LAT];
   logic [PW-1:0]       ti_d [ROM_LAT];
   logic [NDR*DW-1:0]   data_q, data_d;
   logic [NDR-1:0]      vld_q, vld_d;
   logic                ovr_q, ovr_d;

   logic                issue;
   logic                cap;
   logic [PW-1:0]       cap_idx;
   logic [NDR-1:0]      above;
   logic [PW-1:0]       nxt;

   function automatic logic [PW-1:0] low_idx(input logic [NDR-1:0] v);
      logic [PW-1:0] r;
      r = '0;
      for (int i = NDR - 1; i >= 0; i--) begin
         if (v[i]) r = PW'(i);
      end
      return r;
   endfunction

   // Tag leaving the last pipeline stage marks the clock its data is on rom_q
   assign cap     = tv_q[ROM_LAT-1];
   assign cap_idx = ti_q[ROM_LAT-1];

   always_comb begin
      above = '0;
      for (int i = 0; i < NDR; i++) begin
         above[i] = mask_q[i] && (PW'(i) > ptr_q);
      end
   end

   assign nxt = low_idx(above);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      ptr_d   = ptr_q;
      mem_a_d = mem_a_q;
      issue   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ph2_f && (|drv_en)) begin
               mask_d  = drv_en;
               ptr_d   = low_idx(drv_en);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            issue = 1'b1;
            for (int i = 0; i < NDR; i++) begin
               if (ptr_q == PW'(i)) mem_a_d = drv_addr[i*AW +: AW];
            end
            if (|above) ptr_d = nxt;
            else        state_d = DRAIN;
         end
         DRAIN: begin
            // Leave on the edge that consumes the final in-flight tag
            if ((tv_q & ~TOP) == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tv_d    = (tv_q << 1) | ROM_LAT'(issue);
      ti_d[0] = ptr_q;
      for (int j = 1; j < ROM_LAT; j++) begin
         ti_d[j] = ti_q[j-1];
      end
      data_d = data_q;
      vld_d  = '0;
      for (int i = 0; i < NDR; i++) begin
         if (cap && (cap_idx == PW'(i))) begin
            data_d[i*DW +: DW] = rom_q;
            vld_d[i]           = 1'b1;
         end
      end
      ovr_d = (ovr_q & ~ovr_clr) | (ph2_f & (state_q != IDLE));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mask_q  <= '0;
         ptr_q   <= '0;
         mem_a_q <= '0;
         tv_q    <= '0;
         for (int j = 0; j < ROM_LAT; j++) begin
            ti_q[j] <= '0;
         end
         data_q  <= '1;
         vld_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         ptr_q   <= ptr_d;
         mem_a_q <= mem_a_d;
         tv_q    <= tv_d;
         ti_q    <= ti_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         ovr_q   <= ovr_d;
      end
   end

   assign mem_a     = mem_a_q;
   assign drv_data  = data_q;
   assign drv_valid = vld_q;
   assign busy      = (state_q != IDLE);
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_iecdrv_rom_sched.sv
// Bench for iecdrv_rom_sched: scoreboard of expected captures on a 4-drive
// instance, plus NDR/ROM_LAT sweep instances checked against capture timing.
module tb_iecdrv_rom_sched;

   localparam int NDR = 4;
   localparam int AW  = 15;
   localparam int DW  = 8;
   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              ph2_f;
   logic              ovr_clr;
   logic [NDR-1:0]    drv_en;
   logic [NDR*AW-1:0] drv_addr;
   logic [AW-1:0]     mem_a;
   logic [DW-1:0]     rom_q;
   logic [DW-1:0]     rom_r;
   logic [NDR*DW-1:0] drv_data;
   logic [NDR-1:0]    drv_valid;
   logic              busy;
   logic              overrun;

   int ecount = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         edge_n;
      int         idx;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   function automatic logic [7:0] romf(input logic [14:0] a);
      return a[7:0] ^ {1'b0, a[14:8]};
   endfunction

   always @(posedge clk) begin
      ecount <= ecount + 1;
      rom_r  <= romf(mem_a);
   end
   assign rom_q = rom_r;

   iecdrv_rom_sched #(
      .NDR(NDR), .AW(AW), .DW(DW), .ROM_LAT(LAT)
   ) u_dut (
      .clk(clk), .reset(reset), .ph2_f(ph2_f),
      .drv_en(drv_en), .drv_addr(drv_addr), .mem_a(mem_a),
      .rom_q(rom_q), .drv_data(drv_data), .drv_valid(drv_valid),
      .busy(busy), .ovr_clr(ovr_clr), .overrun(overrun)
   );

   localparam int SWN [4] = '{1, 8, 1, 8};
   localparam int SWL [4] = '{1, 1, 4, 4};
   logic             sw_ph2;
   logic [7:0]       sw_en = 8'hFF;
   logic [8*AW-1:0]  sw_addr;

   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int N = SWN[g];
      localparam int L = SWL[g];
      logic [AW-1:0]  ma;
      logic [7:0]     rq;
      logic [N*8-1:0] dd;
      logic [N-1:0]   dv;
      logic           bz;
      logic           ov;
      logic [7:0]     rp [4];
      int             cyc [8];
      logic [7:0]     dat [8];
      int             n = 0;
      logic           multi = 1'b0;

      always @(posedge clk) begin
         rp[0] <= romf(ma);
         for (int j = 1; j < 4; j++) rp[j] <= rp[j-1];
      end
      if (L == 1) begin : g_c
         assign rq = romf(ma);
      end else begin : g_r
         assign rq = rp[L-2];
      end

      iecdrv_rom_sched #(
         .NDR(N), .AW(AW), .DW(8), .ROM_LAT(L)
      ) dut (
         .clk(clk), .reset(reset), .ph2_f(sw_ph2),
         .drv_en(sw_en[N-1:0]), .drv_addr(sw_addr[N*AW-1:0]), .mem_a(ma),
         .rom_q(rq), .drv_data(dd), .drv_valid(dv),
         .busy(bz), .ovr_clr(1'b0), .overrun(ov)
      );

      always @(negedge clk) begin
         if (reset) begin
            n     <= 0;
            multi <= 1'b0;
         end else begin
            n <= n + $countones(dv);
            if ($countones(dv) > 1) multi <= 1'b1;
            for (int i = 0; i < N; i++) begin
               if (dv[i]) begin
                  cyc[i] <= ecount;
                  dat[i] <= dd[i*8 +: 8];
               end
            end
         end
      end
   end

   // One clock step; any capture pulse is matched against the scoreboard head
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (drv_valid !== '0) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected edge=%0d valid=%b", ecount, drv_valid);
         end else begin
            e = sb.pop_front();
            if (e.edge_n != ecount || drv_valid !== (4'b0001 << e.idx) ||
                drv_data[e.idx*8 +: 8] !== e.data) begin
               errors++;
               $display("FAIL sb_capture edge=%0d valid=%b data=%h required edge=%0d idx=%0d data=%h",
                        ecount, drv_valid, drv_data[e.idx*8 +: 8], e.edge_n, e.idx, e.data);
            end
         end
      end else if (sb.size() != 0 && sb[0].edge_n <= ecount) begin
         checks++;
         errors++;
         e = sb.pop_front();
         $display("FAIL sb_missing edge=%0d required idx=%0d at edge=%0d", ecount, e.idx, e.edge_n);
      end
   endtask

   task automatic start_round(input logic [3:0] en);
      exp_t e;
      int   k;
      k      = 0;
      drv_en = en;
      ph2_f  = 1'b1;
      for (int i = 0; i < NDR; i++) begin
         if (en[i]) begin
            e.edge_n = ecount + 2 + k + LAT;
            e.idx    = i;
            e.data   = romf(drv_addr[i*AW +: AW]);
            sb.push_back(e);
            k++;
         end
      end
      tick();
      ph2_f = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      ph2_f    = 1'b1;
      ovr_clr  = 1'b0;
      drv_en   = '1;
      drv_addr = {15'h400, 15'h300, 15'h200, 15'h100};
      sw_ph2   = 1'b0;
      sw_addr  = '0;
      tick();
      tick();
      reset = 1'b0;
      ph2_f = 1'b0;
      tick();
      checks++;
      if (mem_a !== '0) begin errors++; $display("FAIL rst_mem_a got=%h want=0", mem_a); end
      checks++;
      if (drv_data !== '1) begin errors++; $display("FAIL rst_data got=%h want=all-ones", drv_data); end
      checks++;
      if (drv_valid !== '0) begin errors++; $display("FAIL rst_valid got=%b want=0", drv_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%b want=0", overrun); end
   endtask

   task automatic test_sparse();
      drv_addr = {15'h4C3, 15'h3A5, 15'h25A, 15'h1F0};
      start_round(4'b1010);
      drv_en = 4'b1111;
      for (int n = 1; n <= 6; n++) begin
         tick();
         checks++;
         if (mem_a !== ((n == 1) ? 15'h25A : 15'h4C3)) begin
            errors++; $display("FAIL sparse_mem_a step=%0d got=%h", n, mem_a);
         end
         checks++;
         if (busy !== (n < 4)) begin
            errors++; $display("FAIL sparse_busy step=%0d got=%b want=%b", n, busy, (n < 4));
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sparse_pending got=%0d want=0", sb.size()); end
      checks++;
      if (drv_data !== {8'hC7, 8'hFF, 8'h58, 8'hFF}) begin
         errors++; $display("FAIL sparse_data got=%h want=c7ff58ff", drv_data);
      end
   endtask

   task automatic test_zero();
      start_round(4'b0000);
      for (int n = 1; n <= 5; n++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || mem_a !== 15'h4C3) begin
            errors++; $display("FAIL zero_idle step=%0d busy=%b mem_a=%h want 0/4c3", n, busy, mem_a);
         end
      end
   endtask

   task automatic test_full();
      drv_addr = {15'h400, 15'h300, 15'h200, 15'h100};
      start_round(4'b1111);
      for (int n = 1; n <= 8; n++) begin
         tick();
         checks++;
         if (mem_a !== ((n <= 4) ? 15'(n * 15'h100) : 15'h400)) begin
            errors++; $display("FAIL full_mem_a step=%0d got=%h", n, mem_a);
         end
         checks++;
         if (busy !== (n < 6)) begin
            errors++; $display("FAIL full_busy step=%0d got=%b want=%b", n, busy, (n < 6));
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL full_pending got=%0d want=0", sb.size()); end
      for (int i = 0; i < NDR; i++) begin
         checks++;
         if (drv_data[i*8 +: 8] !== 8'(i + 1)) begin
            errors++; $display("FAIL full_data idx=%0d got=%h want=%h", i, drv_data[i*8 +: 8], 8'(i + 1));
         end
      end
   endtask

   task automatic test_overrun();
      drv_addr = {15'h7FF, 15'h0AB, 15'h5CD, 15'h3E1};
      start_round(4'b1111);
      tick();
      ph2_f = 1'b1;
      tick();
      ph2_f = 1'b0;
      for (int n = 0; n < 20 && (sb.size() != 0 || busy); n++) tick();
      checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL ovr_round pending=%0d busy=%b want 0/0", sb.size(), busy);
      end
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b want=1", overrun); end
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b want=0", overrun); end
      start_round(4'b0001);
      ph2_f   = 1'b1;
      ovr_clr = 1'b1;
      tick();
      ph2_f   = 1'b0;
      ovr_clr = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_both got=%b want=1", overrun); end
      for (int n = 0; n < 20 && (sb.size() != 0 || busy); n++) tick();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL ovr_pending got=%0d want=0", sb.size()); end
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
   endtask

   task automatic test_mid_reset();
      drv_addr = {15'h400, 15'h300, 15'h200, 15'h100};
      start_round(4'b1111);
      tick();
      tick();
      reset = 1'b1;
      sb.delete();
      tick();
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || drv_data !== '1) begin
         errors++; $display("FAIL mrst_state busy=%b data=%h want 0/all-ones", busy, drv_data);
      end
      for (int n = 0; n < 6; n++) begin
         checks++;
         if (drv_valid !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL mrst_quiet step=%0d valid=%b busy=%b", n, drv_valid, busy);
         end
         tick();
      end
      drv_addr = {15'h7001, 15'h2468, 15'h0F0F, 15'h1234};
      start_round(4'b1111);
      for (int n = 0; n < 20 && (sb.size() != 0 || busy); n++) tick();
      checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL mrst_clean pending=%0d busy=%b want 0/0", sb.size(), busy);
      end
   endtask

   task automatic test_sweep();
      int         e0;
      int         cy [8];
      logic [7:0] dt [8];
      int         nn;
      logic       mu;
      logic       bz;
      for (int i = 0; i < 8; i++) sw_addr[i*AW +: AW] = 15'((i + 1) * 256 + i * 7);
      e0     = ecount + 1;
      sw_ph2 = 1'b1;
      tick();
      sw_ph2 = 1'b0;
      repeat (20) tick();
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: begin cy = g_sw[0].cyc; dt = g_sw[0].dat; nn = g_sw[0].n; mu = g_sw[0].multi; bz = g_sw[0].bz; end
            1: begin cy = g_sw[1].cyc; dt = g_sw[1].dat; nn = g_sw[1].n; mu = g_sw[1].multi; bz = g_sw[1].bz; end
            2: begin cy = g_sw[2].cyc; dt = g_sw[2].dat; nn = g_sw[2].n; mu = g_sw[2].multi; bz = g_sw[2].bz; end
            default: begin cy = g_sw[3].cyc; dt = g_sw[3].dat; nn = g_sw[3].n; mu = g_sw[3].multi; bz = g_sw[3].bz; end
         endcase
         checks++;
         if (nn != SWN[c] || mu !== 1'b0 || bz !== 1'b0) begin
            errors++; $display("FAIL sweep_count cfg=%0d pulses=%0d multi=%b busy=%b want %0d/0/0", c, nn, mu, bz, SWN[c]);
         end
         for (int k = 0; k < SWN[c]; k++) begin
            checks++;
            if (cy[k] != e0 + 1 + k + SWL[c] || dt[k] !== romf(sw_addr[k*AW +: AW])) begin
               errors++;
               $display("FAIL sweep_capture cfg=%0d idx=%0d edge=%0d data=%h want edge=%0d data=%h",
                        c, k, cy[k], dt[k], e0 + 1 + k + SWL[c], romf(sw_addr[k*AW +: AW]));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sparse();
      test_zero();
      test_full();
      test_overrun();
      test_mid_reset();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
